alu_writeback: RTL and testbench
================================

Name: alu_writeback

Overview:
- Commit stage directly downstream of the integer ALU.
- Latches one ALU result plus its flag image, then commits it:
  - FLAGS always receives the new flag image.
  - The result goes to a general register, or to memory over the core's 8-bit data bus, one byte per cycle.
  - CMP commits flags only.
- Signals completion to the sequencer with a single-cycle done pulse.

Parameters:
- AW, 20, memory address width (8086 physical address; wraps modulo 2^AW).

Ports:
- clock  in  1  system clock, all state on rising edge
- resetn  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; samples all operand inputs below
- isize  in  1  0 = byte, 1 = word/dword (same meaning as ALU)
- opsize  in  1  with isize=1: 0 = 16-bit, 1 = 32-bit
- alumode  in  3  ALU op code; 7 = CMP (no result write)
- dir  in  1  0 = result to register, 1 = result to memory
- regn  in  3  destination register number (x86 encoding)
- ea  in  AW  memory destination address
- result  in  32  ALU result
- flags_in  in  12  ALU flags_o image
- mem_ready  in  1  bus accepts the presented byte this cycle
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- reg_we  out  1  register file write strobe
- reg_n  out  3  register file index (16/32-bit register number)
- reg_mask  out  4  byte-lane enables
- reg_data  out  32  lane-aligned write data
- flags_we  out  1  FLAGS write strobe
- flags_data  out  12  new FLAGS value
- mem_we  out  1  byte write request
- mem_addr  out  AW  byte address
- mem_data  out  8  byte to write

Behaviour:
- Reset:
  - All outputs 0; state IDLE; internal latches cleared.
  - Asserting resetn low mid-write aborts the write immediately. Already-accepted bytes are not undone.
- States: IDLE, COMMIT, MEMW.
- IDLE:
  - busy=0.
  - On start=1, latch all inputs; go to COMMIT next cycle.
- COMMIT (exactly one cycle, busy=1):
  - flags_we=1, flags_data = latched flags_in.
  - If alumode==7: no reg/mem write; done=1; go to IDLE.
  - Else if dir==0: reg_we=1; done=1; go to IDLE.
  - Else (dir==1): byte counter k=0; nbytes = 1 / 2 / 4 per isize/opsize; go to MEMW.
- Register mapping (dir=0):
  - Byte, regn 0..3: reg_n=regn, reg_mask=0001, reg_data={24'b0, result[7:0]}.
  - Byte, regn 4..7: reg_n=regn-4, reg_mask=0010, reg_data={16'b0, result[7:0], 8'b0}.
  - 16-bit: reg_n=regn, reg_mask=0011, reg_data={16'b0, result[15:0]}.
  - 32-bit: reg_n=regn, reg_mask=1111, reg_data=result.
- MEMW (busy=1):
  - mem_we=1, mem_addr=(ea+k) mod 2^AW, mem_data=result[8k+7:8k].
  - If mem_ready=1: k increments. When the last byte (k=nbytes-1) is accepted, done=1 in that same cycle and the next state is IDLE.
  - If mem_ready=0: address and data held stable; no timeout.
- Latency, start to done:
  - Register or CMP: 1 cycle.
  - Memory: 1 + nbytes cycles with mem_ready tied high.
- Strobes: reg_we, flags_we and mem_we are 0 in every cycle not listed above.
- start while busy=1 is ignored; latched operands are not disturbed.
- start in the same cycle as done (back-to-back) is ignored; the earliest accepted start is the cycle after done. The sequencer must not issue start until it sees done.
- Address wrap: ea=0xFFFFF, 16-bit write → bytes to 0xFFFFF, then 0x00000.
- Inputs other than mem_ready are sampled only at start.

Decomposition:
- Shared package (cpu_pkg) holds:
  - ALU mode constants (ADD=0 … CMP=7).
  - FLAGS bit indices (C=0, P=2, A=4, Z=6, S=7, T=8, I=9, D=10, O=11).
  - Writeback state encoding.
- Sub-module alu_wb_regmap: purely combinational isize/opsize/regn → reg_n, reg_mask and lane-aligned reg_data.
- FSM, byte counter and latches remain in alu_writeback.

Test Plan:
- Reset then idle: all outputs 0, busy=0; pulse resetn low in MEMW → mem_we drops asynchronously, state returns to IDLE.
- start, isize=0, regn=4 (AH), result=0x5A, dir=0 → next cycle reg_we=1, reg_n=0, reg_mask=0010, reg_data=0x00005A00, flags_we=1, done=1.
- alumode=7, dir=1, flags_in=0x046 → one cycle: flags_we=1, flags_data=0x046, done=1; mem_we and reg_we never asserted.
- isize=1, opsize=1, dir=1, ea=0x12340, result=0xDEADBEEF, mem_ready=1 → bytes EF, BE, AD, DE at 0x12340..0x12343 on consecutive cycles; done with the last byte; 5 cycles total.
- 16-bit memory write with mem_ready low for 3 cycles on byte 0 → mem_addr and mem_data held stable; bytes complete after ready rises; second start during stall ignored.
- ea=0xFFFFF, 16-bit, result=0x1234 → 0x34 to 0xFFFFF, 0x12 to 0x00000; start asserted in the done cycle ignored, the next cycle's start accepted.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared ALU mode, FLAGS bit and writeback state definitions
//
// Purpose: constants shared by the ALU and its writeback stage.
//   - ALU mode codes (x86 group-1 ordering), CMP writes flags only.
//   - FLAGS bit positions within the 12-bit flag image.
//   - Writeback FSM state encoding.
//   - Helper giving the index of the last byte of an operand.
// Ports: none (package).

package cpu_pkg;

  // ALU mode codes
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_ADC = 3'd2;
  localparam logic [2:0] ALU_SBB = 3'd3;
  localparam logic [2:0] ALU_AND = 3'd4;
  localparam logic [2:0] ALU_SUB = 3'd5;
  localparam logic [2:0] ALU_XOR = 3'd6;
  localparam logic [2:0] ALU_CMP = 3'd7;

  // FLAGS bit indices
  localparam int FLAG_C = 0;
  localparam int FLAG_P = 2;
  localparam int FLAG_A = 4;
  localparam int FLAG_Z = 6;
  localparam int FLAG_S = 7;
  localparam int FLAG_T = 8;
  localparam int FLAG_I = 9;
  localparam int FLAG_D = 10;
  localparam int FLAG_O = 11;

  // Writeback FSM states
  localparam logic [1:0] WB_IDLE   = 2'd0;
  localparam logic [1:0] WB_COMMIT = 2'd1;
  localparam logic [1:0] WB_MEMW   = 2'd2;

  // Index of the final byte: 0 for byte, 1 for 16-bit, 3 for 32-bit operands.
  function automatic logic [1:0] last_byte(input logic isize, input logic opsize);
    if (!isize)     return 2'd0;
    else if (opsize) return 2'd3;
    else            return 2'd1;
  endfunction

endpackage

// File: rtl/alu_wb_regmap.sv
// rtl/alu_wb_regmap.sv - maps operand size and x86 register number to register file lanes
//
// Purpose: combinational translation of an x86 destination register into the
// register file index, byte-lane mask and lane-aligned write data.
// Ports:
//   isize    in  1   0 = byte operand, 1 = word/dword
//   opsize   in  1   with isize=1: 0 = 16-bit, 1 = 32-bit
//   regn     in  3   x86 register encoding
//   result   in  32  ALU result
//   reg_n    out 3   register file index
//   reg_mask out 4   byte-lane enables
//   reg_data out 32  lane-aligned write data

module alu_wb_regmap
  import cpu_pkg::*;
(
  input  logic        isize,
  input  logic        opsize,
  input  logic [2:0]  regn,
  input  logic [31:0] result,
  output logic [2:0]  reg_n,
  output logic [3:0]  reg_mask,
  output logic [31:0] reg_data
);

  always_comb begin
    reg_n    = regn;
    reg_mask = 4'b0000;
    reg_data = 32'h0;
    if (!isize) begin
      // Byte registers 4..7 (AH, CH, DH, BH) are lane 1 of registers 0..3.
      if (regn[2]) begin
        reg_n    = {1'b0, regn[1:0]};
        reg_mask = 4'b0010;
        reg_data = {16'h0, result[7:0], 8'h0};
      end else begin
        reg_mask = 4'b0001;
        reg_data = {24'h0, result[7:0]};
      end
    end else if (!opsize) begin
      reg_mask = 4'b0011;
      reg_data = {16'h0, result[15:0]};
    end else begin
      reg_mask = 4'b1111;
      reg_data = result;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// rtl/alu_writeback.sv - ALU commit stage writing FLAGS plus a register or memory bytes
//
// Purpose: latches one ALU result and its flag image at start, commits FLAGS
// in the following cycle, then writes the result either to the register file
// (same cycle) or to memory one byte per accepted bus cycle. done pulses for
// one cycle when the operation completes.
// Ports:
//   clock, resetn                 clock and asynchronous active-low reset
//   start                         request; samples all operand inputs
//   isize, opsize, alumode, dir   operand size, ALU mode, destination select
//   regn, ea, result, flags_in    destination register/address, data, flags
//   mem_ready                     bus accepts the presented byte
//   busy, done                    status and completion pulse
//   reg_we, reg_n, reg_mask, reg_data   register file write port
//   flags_we, flags_data          FLAGS write port
//   mem_we, mem_addr, mem_data    byte-wide memory write port

module alu_writeback
  import cpu_pkg::*;
#(
  parameter int AW = 20
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          start,
  input  logic          isize,
  input  logic          opsize,
  input  logic [2:0]    alumode,
  input  logic          dir,
  input  logic [2:0]    regn,
  input  logic [AW-1:0] ea,
  input  logic [31:0]   result,
  input  logic [11:0]   flags_in,
  input  logic          mem_ready,
  output logic          busy,
  output logic          done,
  output logic          reg_we,
  output logic [2:0]    reg_n,
  output logic [3:0]    reg_mask,
  output logic [31:0]   reg_data,
  output logic          flags_we,
  output logic [11:0]   flags_data,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_data
);

  logic [1:0]    state;
  logic [1:0]    k;
  logic [1:0]    last_q;
  logic          isize_q;
  logic          opsize_q;
  logic [2:0]    alumode_q;
  logic          dir_q;
  logic [2:0]    regn_q;
  logic [AW-1:0] ea_q;
  logic [31:0]   result_q;
  logic [11:0]   flags_q;

  logic [2:0]    map_n;
  logic [3:0]    map_mask;
  logic [31:0]   map_data;

  logic          commit_only;
  logic          last_accept;

  alu_wb_regmap u_regmap (
    .isize    (isize_q),
    .opsize   (opsize_q),
    .regn     (regn_q),
    .result   (result_q),
    .reg_n    (map_n),
    .reg_mask (map_mask),
    .reg_data (map_data)
  );

  // COMMIT finishes the operation itself for CMP and for register writes.
  assign commit_only = (alumode_q == ALU_CMP) || !dir_q;
  assign last_accept = (state == WB_MEMW) && mem_ready && (k == last_q);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= WB_IDLE;
      k         <= 2'd0;
      last_q    <= 2'd0;
      isize_q   <= 1'b0;
      opsize_q  <= 1'b0;
      alumode_q <= 3'd0;
      dir_q     <= 1'b0;
      regn_q    <= 3'd0;
      ea_q      <= '0;
      result_q  <= 32'h0;
      flags_q   <= 12'h0;
    end else begin
      case (state)
        WB_IDLE: begin
          if (start) begin
            isize_q   <= isize;
            opsize_q  <= opsize;
            alumode_q <= alumode;
            dir_q     <= dir;
            regn_q    <= regn;
            ea_q      <= ea;
            result_q  <= result;
            flags_q   <= flags_in;
            last_q    <= last_byte(isize, opsize);
            state     <= WB_COMMIT;
          end
        end
        WB_COMMIT: begin
          k     <= 2'd0;
          state <= commit_only ? WB_IDLE : WB_MEMW;
        end
        WB_MEMW: begin
          if (mem_ready) begin
            if (k == last_q) begin
              k     <= 2'd0;
              state <= WB_IDLE;
            end else begin
              k <= k + 2'd1;
            end
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

  // Outputs decode directly from state so an asynchronous reset drops every
  // strobe at once; data buses are zeroed whenever their strobe is low.
  always_comb begin
    busy       = (state == WB_COMMIT) || (state == WB_MEMW);
    flags_we   = (state == WB_COMMIT);
    flags_data = flags_we ? flags_q : 12'h0;
    reg_we     = (state == WB_COMMIT) && (alumode_q != ALU_CMP) && !dir_q;
    reg_n      = reg_we ? map_n : 3'd0;
    reg_mask   = reg_we ? map_mask : 4'b0000;
    reg_data   = reg_we ? map_data : 32'h0;
    mem_we     = (state == WB_MEMW);
    mem_addr   = mem_we ? (ea_q + AW'(k)) : '0;
    mem_data   = mem_we ? result_q[{k, 3'b000} +: 8] : 8'h0;
    done       = ((state == WB_COMMIT) && commit_only) || last_accept;
  end

endmodule

// File: tb/tb_alu_writeback.sv
// tb/tb_alu_writeback.sv - directed self-checking bench for alu_writeback

module tb_alu_writeback;

  localparam int AW = 20;

  logic          clock = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          isize = 1'b0;
  logic          opsize = 1'b0;
  logic [2:0]    alumode = 3'd0;
  logic          dir = 1'b0;
  logic [2:0]    regn = 3'd0;
  logic [AW-1:0] ea = '0;
  logic [31:0]   result = 32'h0;
  logic [11:0]   flags_in = 12'h0;
  logic          mem_ready = 1'b0;
  logic          busy, done, reg_we, flags_we, mem_we;
  logic [2:0]    reg_n;
  logic [3:0]    reg_mask;
  logic [31:0]   reg_data;
  logic [11:0]   flags_data;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_data;

  int checks = 0;
  int errors = 0;

  alu_writeback #(.AW(AW)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .isize      (isize),
    .opsize     (opsize),
    .alumode    (alumode),
    .dir        (dir),
    .regn       (regn),
    .ea         (ea),
    .result     (result),
    .flags_in   (flags_in),
    .mem_ready  (mem_ready),
    .busy       (busy),
    .done       (done),
    .reg_we     (reg_we),
    .reg_n      (reg_n),
    .reg_mask   (reg_mask),
    .reg_data   (reg_data),
    .flags_we   (flags_we),
    .flags_data (flags_data),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle just after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic is, input logic os, input logic [2:0] mode,
                      input logic d, input logic [2:0] r, input logic [AW-1:0] a,
                      input logic [31:0] res, input logic [11:0] fl);
    start = 1'b1; isize = is; opsize = os; alumode = mode; dir = d;
    regn = r; ea = a; result = res; flags_in = fl;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_reg_we"}, {31'b0, reg_we}, 32'd0);
    check({tag, "_flags_we"}, {31'b0, flags_we}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
  endtask

  task automatic check_mem(input string tag, input logic [AW-1:0] a, input logic [7:0] b,
                           input logic dn);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd1);
    check({tag, "_addr"}, {12'b0, mem_addr}, {12'b0, a});
    check({tag, "_data"}, {24'b0, mem_data}, {24'b0, b});
    check({tag, "_done"}, {31'b0, done}, {31'b0, dn});
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
  endtask

  initial begin
    // Reset state
    #12;
    check_quiet("rst");
    check("rst_reg_data", reg_data, 32'h0);
    check("rst_mem_addr", {12'b0, mem_addr}, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    tick();
    check_quiet("idle");

    // AH byte write
    load(1'b0, 1'b0, 3'd0, 1'b0, 3'd4, 20'h0, 32'h0000005A, 12'h801);
    tick();
    start = 1'b0;
    check("ah_reg_we", {31'b0, reg_we}, 32'd1);
    check("ah_reg_n", {29'b0, reg_n}, 32'd0);
    check("ah_mask", {28'b0, reg_mask}, 32'h2);
    check("ah_data", reg_data, 32'h00005A00);
    check("ah_flags_we", {31'b0, flags_we}, 32'd1);
    check("ah_flags", {20'b0, flags_data}, 32'h801);
    check("ah_done", {31'b0, done}, 32'd1);
    check("ah_mem_we", {31'b0, mem_we}, 32'd0);
    tick();
    check_quiet("ah_after");

    // CL byte write (low lane)
    load(1'b0, 1'b0, 3'd5, 1'b0, 3'd1, 20'h0, 32'h000000C3, 12'h000);
    tick();
    start = 1'b0;
    check("cl_reg_n", {29'b0, reg_n}, 32'd1);
    check("cl_mask", {28'b0, reg_mask}, 32'h1);
    check("cl_data", reg_data, 32'h000000C3);
    tick();

    // 32-bit register write
    load(1'b1, 1'b1, 3'd0, 1'b0, 3'd6, 20'h0, 32'h12345678, 12'h004);
    tick();
    start = 1'b0;
    check("d32_reg_n", {29'b0, reg_n}, 32'd6);
    check("d32_mask", {28'b0, reg_mask}, 32'hF);
    check("d32_data", reg_data, 32'h12345678);
    tick();

    // CMP with dir=1: flags only
    load(1'b1, 1'b0, 3'd7, 1'b1, 3'd2, 20'h00400, 32'hFFFF0000, 12'h046);
    tick();
    start = 1'b0;
    check("cmp_flags_we", {31'b0, flags_we}, 32'd1);
    check("cmp_flags", {20'b0, flags_data}, 32'h046);
    check("cmp_done", {31'b0, done}, 32'd1);
    check("cmp_mem_we", {31'b0, mem_we}, 32'd0);
    check("cmp_reg_we", {31'b0, reg_we}, 32'd0);
    tick();
    check_quiet("cmp_after");

    // 32-bit memory write, ready high: done 5 cycles after start
    mem_ready = 1'b1;
    load(1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 20'h12340, 32'hDEADBEEF, 12'h0C0);
    tick();
    start = 1'b0;
    check("m32_commit_flags_we", {31'b0, flags_we}, 32'd1);
    check("m32_commit_done", {31'b0, done}, 32'd0);
    check("m32_commit_mem_we", {31'b0, mem_we}, 32'd0);
    check("m32_commit_reg_we", {31'b0, reg_we}, 32'd0);
    tick(); check_mem("m32_b0", 20'h12340, 8'hEF, 1'b0);
    check("m32_b0_flags_we", {31'b0, flags_we}, 32'd0);
    tick(); check_mem("m32_b1", 20'h12341, 8'hBE, 1'b0);
    tick(); check_mem("m32_b2", 20'h12342, 8'hAD, 1'b0);
    tick(); check_mem("m32_b3", 20'h12343, 8'hDE, 1'b1);
    tick();
    check_quiet("m32_after");

    // 16-bit memory write with a 3-cycle stall on byte 0 and a start during it
    mem_ready = 1'b0;
    load(1'b1, 1'b0, 3'd2, 1'b1, 3'd0, 20'h00100, 32'h0000A55A, 12'h010);
    tick();
    load(1'b1, 1'b1, 3'd0, 1'b0, 3'd3, 20'h55555, 32'hFFFFFFFF, 12'hFFF);
    tick(); check_mem("stall0", 20'h00100, 8'h5A, 1'b0);
    tick(); check_mem("stall1", 20'h00100, 8'h5A, 1'b0);
    tick(); check_mem("stall2", 20'h00100, 8'h5A, 1'b0);
    start = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_mem("stall_rdy", 20'h00100, 8'h5A, 1'b0);
    tick(); check_mem("stall_b1", 20'h00101, 8'hA5, 1'b1);
    tick();
    check_quiet("stall_after");

    // Address wrap plus start in the done cycle
    load(1'b1, 1'b0, 3'd0, 1'b1, 3'd0, 20'hFFFFF, 32'h00001234, 12'h000);
    tick();
    start = 1'b0;
    tick(); check_mem("wrap_b0", 20'hFFFFF, 8'h34, 1'b0);
    tick(); check_mem("wrap_b1", 20'h00000, 8'h12, 1'b1);
    load(1'b1, 1'b0, 3'd0, 1'b0, 3'd3, 20'h0, 32'h0000BEEF, 12'h001);
    tick();
    check_quiet("b2b_ignored");
    tick();
    start = 1'b0;
    check("b2b_reg_we", {31'b0, reg_we}, 32'd1);
    check("b2b_reg_n", {29'b0, reg_n}, 32'd3);
    check("b2b_mask", {28'b0, reg_mask}, 32'h3);
    check("b2b_data", reg_data, 32'h0000BEEF);
    check("b2b_done", {31'b0, done}, 32'd1);
    tick();

    // Asynchronous reset mid memory write
    mem_ready = 1'b0;
    load(1'b1, 1'b1, 3'd0, 1'b1, 3'd0, 20'h00200, 32'h11223344, 12'h000);
    tick();
    start = 1'b0;
    tick(); check_mem("arst_pre", 20'h00200, 8'h44, 1'b0);
    #2 resetn = 1'b0;
    #1;
    check_quiet("arst");
    @(negedge clock);
    resetn = 1'b1;
    mem_ready = 1'b1;
    tick();
    check_quiet("arst_idle");
    tick();
    check_quiet("arst_idle2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
